// File: rtl/prog_loader.sv
// prog_loader: program RAM writer with opcode check (PROG_LOADER_OPCHECK_EN) and registered read port
module prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int OPW   = 4,
    parameter int DW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [OPW+DW-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              load_done,
    output logic              err,
    output logic [AW:0]       count,
    input  logic [AW-1:0]     rd_addr,
    output logic [OPW-1:0]    rd_op,
    output logic [DW-1:0]     rd_data
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
`ifdef PROG_LOADER_OPCHECK_EN
        , ERROR
`endif
    } state_t;

    state_t            state, nstate;
    logic [AW-1:0]     wr_ptr;
    logic [OPW+DW-1:0] mem [DEPTH];
    logic              accept, legal, wr_en;

    assign accept = (state == LOAD) && in_valid && !start;
`ifdef PROG_LOADER_OPCHECK_EN
    assign legal = in_data[OPW+DW-1:DW] <= OPW'(4);
`else
    assign legal = 1'b1;
`endif
    assign wr_en = accept && legal;

    // Next state and state-decoded outputs; start always wins over a word in flight
    always_comb begin
        nstate    = state;
        in_ready  = state == LOAD;
        load_done = state == DONE;
`ifdef PROG_LOADER_OPCHECK_EN
        err       = state == ERROR;
`else
        err       = 1'b0;
`endif
        if (start)
            nstate = LOAD;
`ifdef PROG_LOADER_OPCHECK_EN
        else if (accept && !legal)
            nstate = ERROR;
`endif
        else if (wr_en && (in_last || wr_ptr == AW'(DEPTH - 1)))
            nstate = DONE;
    end

    // State register, write pointer and session word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= nstate;
            if (start) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + 1'b1;
            end
        end
    end

    // Program RAM write; contents survive reset and restarts
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= in_data;
    end

    // Registered read port; a same-address write this cycle returns the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_op   <= '0;
            rd_data <= '0;
        end else begin
            rd_op   <= mem[rd_addr][OPW+DW-1:DW];
            rd_data <= mem[rd_addr][DW-1:0];
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader against a session-level model
module tb_prog_loader;
    logic       clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
    logic [7:0] in_data = 0;
    logic [3:0] rd_addr = 0;
    logic       in_ready, load_done, err;
    logic [4:0] count;
    logic [3:0] rd_op, rd_data;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .load_done(load_done), .err(err), .count(count),
        .rd_addr(rd_addr), .rd_op(rd_op), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] mem_m [16];
    bit known [16];
    bit loading = 0, done_m = 0, err_m = 0;
    int cnt_m = 0;

    task automatic do_start();
        start = 1;
        @(negedge clk);
        start = 0;
        loading = 1; done_m = 0; err_m = 0; cnt_m = 0;
    endtask

    task automatic send(input logic [7:0] w, input bit last);
        bit legal;
        in_valid = 1; in_data = w; in_last = last;
        @(negedge clk);
        in_valid = 0; in_last = 0;
        if (loading) begin
`ifdef PROG_LOADER_OPCHECK_EN
            legal = w[7:4] <= 4;
`else
            legal = 1;
`endif
            if (!legal) begin
                err_m = 1; loading = 0;
            end else begin
                mem_m[cnt_m] = w; known[cnt_m] = 1; cnt_m++;
                if (last || cnt_m == 16) begin done_m = 1; loading = 0; end
            end
        end
    endtask

    task automatic rd(input int a);
        rd_addr = a[3:0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (load_done !== 0) begin errors++; $display("FAIL reset_load_done got %b exp 0", load_done); end
        checks++; if (err !== 0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if ({rd_op, rd_data} !== 8'h00) begin errors++; $display("FAIL reset_rd got %h exp 00", {rd_op, rd_data}); end
        rst_n = 1;
        @(negedge clk);
        do_start();
        send(8'h13, 0);
        send(8'h24, 0);
        rd(1);
        #2 rst_n = 0;
        #1;
        checks++; if (in_ready !== 0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
        checks++; if (count !== 0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
        checks++; if (load_done !== 0 || err !== 0) begin errors++; $display("FAIL midrst_flags got %b%b exp 00", load_done, err); end
        checks++; if ({rd_op, rd_data} !== 8'h00) begin errors++; $display("FAIL midrst_rd got %h exp 00", {rd_op, rd_data}); end
        loading = 0; done_m = 0; err_m = 0; cnt_m = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++; if (in_ready !== 0) begin errors++; $display("FAIL postrst_idle_ready got %b exp 0", in_ready); end
        do_start();
        send(8'h33, 1);
        checks++; if (count !== 1) begin errors++; $display("FAIL postrst_count got %0d exp 1", count); end
        rd(0);
        checks++; if ({rd_op, rd_data} !== 8'h33) begin errors++; $display("FAIL postrst_addr0 got %h exp 33", {rd_op, rd_data}); end
    endtask

    task automatic test_normal();
        logic [7:0] words [5] = '{8'h04, 8'h12, 8'h20, 8'h30, 8'h40};
        do_start();
        checks++; if (in_ready !== 1) begin errors++; $display("FAIL normal_ready got %b exp 1", in_ready); end
        for (int i = 0; i < 5; i++) send(words[i], i == 4);
        checks++; if (load_done !== 1) begin errors++; $display("FAIL normal_done got %b exp 1", load_done); end
        checks++; if (count !== 5) begin errors++; $display("FAIL normal_count got %0d exp 5", count); end
        checks++; if (in_ready !== 0) begin errors++; $display("FAIL normal_ready_after got %b exp 0", in_ready); end
        for (int a = 0; a < 5; a++) begin
            rd(a);
            checks++;
            if ({rd_op, rd_data} !== words[a]) begin errors++; $display("FAIL normal_rd%0d got %h exp %h", a, {rd_op, rd_data}, words[a]); end
        end
    endtask

    task automatic test_full();
        logic [7:0] keep0;
        do_start();
        for (int i = 0; i < 16; i++) send({4'($urandom_range(0, 4)), 4'($urandom)}, 0);
        checks++; if (load_done !== 1) begin errors++; $display("FAIL full_done got %b exp 1", load_done); end
        checks++; if (count !== 16) begin errors++; $display("FAIL full_count got %0d exp 16", count); end
        checks++; if (in_ready !== 0) begin errors++; $display("FAIL full_ready got %b exp 0", in_ready); end
        keep0 = mem_m[0];
        send(~keep0 & 8'h4F, 0);
        checks++; if (count !== 16) begin errors++; $display("FAIL full_extra_count got %0d exp 16", count); end
        rd(0);
        checks++; if ({rd_op, rd_data} !== keep0) begin errors++; $display("FAIL full_extra_addr0 got %h exp %h", {rd_op, rd_data}, keep0); end
        for (int a = 1; a < 16; a++) begin
            rd(a);
            checks++;
            if ({rd_op, rd_data} !== mem_m[a]) begin errors++; $display("FAIL full_rd%0d got %h exp %h", a, {rd_op, rd_data}, mem_m[a]); end
        end
    endtask

    task automatic test_restart();
        do_start();
        send(8'h40, 0);
        send(8'h03, 0);
        send(8'h2C, 0);
        start = 1; in_valid = 1; in_data = 8'h11;
        @(negedge clk);
        start = 0; in_valid = 0;
        loading = 1; done_m = 0; err_m = 0; cnt_m = 0;
        checks++; if (count !== 0) begin errors++; $display("FAIL restart_count got %0d exp 0", count); end
        checks++; if (in_ready !== 1) begin errors++; $display("FAIL restart_ready got %b exp 1", in_ready); end
        rd(0);
        checks++; if ({rd_op, rd_data} !== 8'h40) begin errors++; $display("FAIL restart_addr0 got %h exp 40", {rd_op, rd_data}); end
        send(8'h22, 1);
        rd(0);
        checks++; if ({rd_op, rd_data} !== 8'h22) begin errors++; $display("FAIL restart_new0 got %h exp 22", {rd_op, rd_data}); end
        checks++; if (count !== 1 || load_done !== 1) begin errors++; $display("FAIL restart_done got cnt %0d done %b exp cnt 1 done 1", count, load_done); end
    endtask

`ifdef PROG_LOADER_OPCHECK_EN
    task automatic test_opcheck();
        logic [7:0] old1;
        old1 = mem_m[1];
        do_start();
        send(8'h04, 0);
        send(8'h5A, 0);
        checks++; if (err !== 1) begin errors++; $display("FAIL op_err got %b exp 1", err); end
        checks++; if (count !== 1) begin errors++; $display("FAIL op_count got %0d exp 1", count); end
        checks++; if (in_ready !== 0 || load_done !== 0) begin errors++; $display("FAIL op_ready_done got %b%b exp 00", in_ready, load_done); end
        rd(1);
        checks++; if ({rd_op, rd_data} !== old1) begin errors++; $display("FAIL op_addr1 got %h exp %h", {rd_op, rd_data}, old1); end
        do_start();
        checks++; if (err !== 0 || count !== 0) begin errors++; $display("FAIL op_restart got err %b cnt %0d exp err 0 cnt 0", err, count); end
    endtask
`else
    task automatic test_nocheck();
        do_start();
        send(8'h5A, 1);
        checks++; if (load_done !== 1) begin errors++; $display("FAIL nochk_done got %b exp 1", load_done); end
        checks++; if (err !== 0) begin errors++; $display("FAIL nochk_err got %b exp 0", err); end
        checks++; if (count !== 1) begin errors++; $display("FAIL nochk_count got %0d exp 1", count); end
        rd(0);
        checks++; if ({rd_op, rd_data} !== 8'h5A) begin errors++; $display("FAIL nochk_addr0 got %h exp 5a", {rd_op, rd_data}); end
    endtask
`endif

    task automatic test_random();
        for (int s = 0; s < 8; s++) begin
            int len;
            len = $urandom_range(1, 20);
            do_start();
            for (int i = 0; i < len && loading; i++) begin
                logic [7:0] w;
                repeat ($urandom_range(0, 2)) @(negedge clk);
`ifdef PROG_LOADER_OPCHECK_EN
                w = ($urandom_range(0, 9) == 0) ? {4'($urandom_range(5, 15)), 4'($urandom)} : {4'($urandom_range(0, 4)), 4'($urandom)};
`else
                w = 8'($urandom);
`endif
                send(w, (i == len - 1) && ($urandom_range(0, 1) == 1));
                checks++;
                if (count !== 5'(cnt_m) || in_ready !== loading || load_done !== done_m || err !== err_m) begin
                    errors++;
                    $display("FAIL rand_s%0d_w%0d got cnt %0d rdy %b done %b err %b exp cnt %0d rdy %b done %b err %b",
                             s, i, count, in_ready, load_done, err, cnt_m, loading, done_m, err_m);
                end
            end
            for (int a = 0; a < 16; a++) begin
                if (known[a]) begin
                    rd(a);
                    checks++;
                    if ({rd_op, rd_data} !== mem_m[a]) begin errors++; $display("FAIL rand_s%0d_rd%0d got %h exp %h", s, a, {rd_op, rd_data}, mem_m[a]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_full();
        test_restart();
`ifdef PROG_LOADER_OPCHECK_EN
        test_opcheck();
`else
        test_nocheck();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and instruction store for the accumulator CPU. It accepts a stream of packed instruction bytes over a valid/ready handshake and writes them into an internal program RAM. It validates opcodes and signals when the program is complete. The CPU's program counter reads the same RAM through a registered read port, so this block is the writer side of the instruction memory that the sequencer reads.

## Interface
- DEPTH, 16: number of program words.
- AW, 4: address width; DEPTH == 2**AW.
- OPW, 4: opcode field width.
- DW, 4: operand field width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins (or restarts) a load session.
- in_valid  in  1  in_data/in_last are valid.
- in_data  in  OPW+DW  instruction word: [7:4] opcode, [3:0] operand.
- in_last  in  1  qualifies the final word of the program (sampled with in_valid).
- in_ready  out  1  block accepts a word this cycle.
- load_done  out  1  program complete; level output until the next start.
- err  out  1  sticky illegal-opcode flag.
- count  out  AW+1  words written in the current session (0..DEPTH).
- rd_addr  in  AW  read address from the program counter.
- rd_op  out  OPW  registered opcode at rd_addr.
- rd_data  out  DW  registered operand at rd_addr.

## Operation
- Legal opcodes: CLEARLD=0, ADDLD=1, ADD=2, SHTR=3, DISP=4. Values 5..15 are illegal.
- FSM states: IDLE, LOAD, DONE, ERROR. Reset state is IDLE.
- IDLE: in_ready=0. On start, go to LOAD, set wr_ptr=0 and count=0, clear err.
- LOAD: in_ready=1. A word is accepted when in_valid && in_ready.
  - Legal opcode: write mem[wr_ptr] <= in_data, then increment wr_ptr and count.
  - Go to DONE if in_last=1, or if this write fills address DEPTH-1 (auto-terminate when full; in_last is ignored in that case).
  - Illegal opcode: the word is not written, count is unchanged, err is set to 1, and the FSM goes to ERROR.
- DONE: load_done=1 and in_ready=0. On start, go to LOAD (clears load_done, count, wr_ptr).
- ERROR: err=1 and in_ready=0. On start, go to LOAD and clear err.
- A start pulse in LOAD aborts and restarts the session: wr_ptr=0, count=0. If in_valid is asserted in the same cycle, start wins and the word is dropped (not written).
- The RAM is not cleared by reset or by start. Locations not written this session keep their old contents.
- The read port is always active in every state, including mid-load. A read and a write to the same address in the same cycle returns the old data.
- The ERROR state and the err flag exist only when the opcode check is compiled in (see Configuration).

## Timing
- Reset values: in_ready=0, load_done=0, err=0, count=0, rd_op=0, rd_data=0. Assertion of rst_n forces IDLE immediately, including mid-load. An in-progress word is lost.
- in_ready is decoded from registered state, so it is glitch-free. It rises the cycle after the start edge.
- Write latency: data is in the RAM on the accepting posedge. count updates on the same edge.
- load_done and err rise on the clock edge that accepts the final or offending word. in_ready is 0 from the following cycle.
- Read latency is 1 cycle: rd_addr is sampled at posedge N, and rd_op/rd_data are valid after posedge N. This is stable before the program counter's negedge update.
- Throughput is one word per cycle while in LOAD.

## Configuration
- PROG_LOADER_OPCHECK_EN
  - Defined: opcodes greater than 4 are rejected, err is set, and the FSM enters ERROR.
  - Undefined: every opcode is accepted and stored, err is tied to 0, and the ERROR state is not implemented.

## Test plan
- Reset mid-load: after start, push 2 words, then pulse rst_n low. Required: in_ready=0, load_done=0, err=0, count=0, rd_op=0, rd_data=0; a subsequent start begins at address 0.
- Normal load: start, then push 0x04, 0x12, 0x20, 0x30, 0x40 with in_last on the 5th. Required: load_done=1, count=5. Then rd_addr=0..4 returns (0,4), (1,2), (2,0), (3,0), (4,0) one cycle after each address.
- Illegal opcode (macro defined): push 0x04, then 0x5A. Required: err=1, count=1, in_ready=0, mem[1] unchanged. A following start gives err=0, count=0.
- Full: push 16 legal words with no in_last. Required: load_done=1 after the 16th word, count=16, in_ready=0; a 17th in_valid is not accepted.
- Restart collision: after 3 words, assert start together with in_valid (data 0x11). Required: count=0 and mem[0] unchanged. The next word 0x22 is written to address 0.
- Macro undefined: push 0x5A with in_last. Required: accepted, load_done=1, err=0, and rd_addr=0 returns (5, 0xA).
